// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: common scalars, the data-memory bus
// records and the LSU opcode, error and state encodings.
package Common;
    typedef logic [31:0] uint32;
endpackage

package MemoryBus;
    import Common::*;

    typedef struct packed {
        uint32      address;
        uint32      write_data;
        logic       mem_read;
        logic       mem_write;
        logic [3:0] mask_byte;
    } Cmd;

    typedef struct packed {
        uint32 read_data;
    } Result;
endpackage

package Lsu;
    typedef enum logic [2:0] {
        LS_B  = 3'd0,
        LS_H  = 3'd1,
        LS_W  = 3'd2,
        LS_BU = 3'd4,
        LS_HU = 3'd5
    } funct3_e;

    typedef enum logic [1:0] {
        ERR_NONE         = 2'd0,
        ERR_MISALIGNED   = 2'd1,
        ERR_ACCESS_FAULT = 2'd2,
        ERR_ILLEGAL      = 2'd3
    } lsu_err_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_e;

    // Access width in bytes; unknown opcodes report 1 so the range check stays defined.
    function automatic logic [2:0] byte_size(input logic [2:0] f3);
        case (f3)
            LS_W:        byte_size = 3'd4;
            LS_H, LS_HU: byte_size = 3'd2;
            default:     byte_size = 3'd1;
        endcase
    endfunction
endpackage

// File: rtl/load_store_unit_lane_align.sv
// Pure data path: byte-lane mask for stores and lane extraction plus
// sign/zero extension for loads.
module lsu_lane_align
    import Lsu::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] read_data,
    output logic [3:0]  mask_byte,
    output logic [31:0] load_data
);
    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Select the addressed lane, then extend according to the opcode.
    always_comb begin
        byte_s    = read_data[{addr_lo, 3'b000} +: 8];
        half_s    = read_data[{addr_lo[1], 4'b0000} +: 16];
        mask_byte = 4'd0;
        load_data = 32'd0;
        case (funct3)
            LS_B: begin
                mask_byte = 4'b0001 << addr_lo;
                load_data = {{24{byte_s[7]}}, byte_s};
            end
            LS_BU: begin
                mask_byte = 4'b0001 << addr_lo;
                load_data = {24'd0, byte_s};
            end
            LS_H: begin
                mask_byte = 4'b0011 << addr_lo;
                load_data = {{16{half_s[15]}}, half_s};
            end
            LS_HU: begin
                mask_byte = 4'b0011 << addr_lo;
                load_data = {16'd0, half_s};
            end
            LS_W: begin
                mask_byte = 4'b1111;
                load_data = read_data;
            end
            default: begin
                mask_byte = 4'd0;
                load_data = 32'd0;
            end
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: validates one request at a time, issues a single-cycle
// memory command for legal requests and returns data/error over valid/ready.
module load_store_unit
    import Lsu::*;
#(
    parameter logic [31:0] DMEM_BASE = 32'h0000_0000,
    parameter int unsigned DMEM_SIZE = 4096
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_store,
    input  logic [2:0]       req_funct3,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_rdata,
    output logic [1:0]       resp_err,
    output MemoryBus::Cmd    membuscmd,
    input  MemoryBus::Result membusres
);
    // 33-bit bounds so an access ending past 4 GiB cannot wrap into range.
    localparam logic [32:0] RANGE_LO = {1'b0, DMEM_BASE};
    localparam logic [32:0] RANGE_HI = {1'b0, DMEM_BASE} + 33'(DMEM_SIZE);

    lsu_state_e    state_q, state_d;
    logic          store_q, store_d;
    logic [2:0]    funct3_q, funct3_d;
    Common::uint32 addr_q, addr_d;
    Common::uint32 wdata_q, wdata_d;
    Common::uint32 rdata_q, rdata_d;
    lsu_err_e      err_q, err_d;

    lsu_err_e      err_s;
    logic [2:0]    size_s;
    logic [32:0]   last_s;
    logic [3:0]    lane_mask_s;
    logic [31:0]   lane_data_s;

    lsu_lane_align u_lane_align (
        .funct3    (funct3_q),
        .addr_lo   (addr_q[1:0]),
        .read_data (membusres.read_data),
        .mask_byte (lane_mask_s),
        .load_data (lane_data_s)
    );

    // Classify the incoming request: illegal > misaligned > access fault.
    always_comb begin
        size_s = byte_size(req_funct3);
        last_s = {1'b0, req_addr} + {30'd0, size_s} - 33'd1;
        if ((req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7) ||
            (req_store && ((req_funct3 == LS_BU) || (req_funct3 == LS_HU)))) begin
            err_s = ERR_ILLEGAL;
        end else if ((((req_funct3 == LS_H) || (req_funct3 == LS_HU)) && req_addr[0]) ||
                     ((req_funct3 == LS_W) && (req_addr[1:0] != 2'b00))) begin
            err_s = ERR_MISALIGNED;
        end else if (({1'b0, req_addr} < RANGE_LO) || (last_s >= RANGE_HI)) begin
            err_s = ERR_ACCESS_FAULT;
        end else begin
            err_s = ERR_NONE;
        end
    end

    // Next-state and datapath register updates.
    always_comb begin
        state_d  = state_q;
        store_d  = store_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    store_d  = req_store;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    rdata_d  = 32'd0;
                    err_d    = err_s;
                    state_d  = (err_s == ERR_NONE) ? ACCESS : RESP;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                rdata_d = store_q ? 32'd0 : lane_data_s;
                err_d   = ERR_NONE;
                state_d = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            store_q  <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            err_q    <= ERR_NONE;
        end else begin
            state_q  <= state_d;
            store_q  <= store_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Bus command is live only in ACCESS; rst_n gating kills a write the instant reset asserts.
    always_comb begin
        membuscmd = '0;
        if ((state_q == ACCESS) && rst_n) begin
            membuscmd.address = {addr_q[31:2], 2'b00};
            if (store_q) begin
                membuscmd.mem_write  = 1'b1;
                membuscmd.write_data = wdata_q;
                membuscmd.mask_byte  = lane_mask_s;
            end else begin
                membuscmd.mem_read = 1'b1;
            end
        end else begin
            membuscmd = '0;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, back-pressure
// and reset-abort sequences, then random traffic against a byte-level model.
module tb_load_store_unit;
    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid, req_ready, req_store;
    logic [2:0]       req_funct3;
    logic [31:0]      req_addr, req_wdata;
    logic             resp_valid, resp_ready;
    logic [31:0]      resp_rdata;
    logic [1:0]       resp_err;
    MemoryBus::Cmd    membuscmd;
    MemoryBus::Result membusres;

    int tests = 0;
    int fails = 0;

    load_store_unit #(.DMEM_BASE(32'h0000_0000), .DMEM_SIZE(4096)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .membuscmd(membuscmd), .membusres(membusres)
    );

    always #5 clk = ~clk;

    // Memory slave (word array) and independent reference memory (byte array).
    bit [31:0]    mem_w [1024];
    byte unsigned ref_b [4096];

    always_comb begin
        membusres = '0;
        membusres.read_data = mem_w[membuscmd.address[11:2]];
    end

    // Low bytes of write_data go into the masked lanes in ascending order.
    function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] wd, input bit [3:0] m);
        bit [31:0] w;
        int j;
        w = old;
        j = 0;
        for (int l = 0; l < 4; l++) begin
            if (m[l]) begin
                w[8*l +: 8] = wd[8*j +: 8];
                j++;
            end
        end
        return w;
    endfunction

    always @(posedge clk) begin
        if (membuscmd.mem_write)
            mem_w[membuscmd.address[11:2]] <= merge(mem_w[membuscmd.address[11:2]],
                                                    membuscmd.write_data, membuscmd.mask_byte);
    end

    int        n_read = 0, n_write = 0;
    bit [31:0] cap_addr, cap_wdata;
    bit [3:0]  cap_mask;
    always @(negedge clk) begin
        if (membuscmd.mem_read) n_read = n_read + 1;
        if (membuscmd.mem_write) begin
            n_write   = n_write + 1;
            cap_addr  = membuscmd.address;
            cap_wdata = membuscmd.write_data;
            cap_mask  = membuscmd.mask_byte;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    function automatic int sz_of(input bit [2:0] f3);
        if (f3 == 3'd2) return 4;
        else if (f3 == 3'd1 || f3 == 3'd5) return 2;
        else return 1;
    endfunction

    // Reference: classify by the architectural rules, then read/update the byte memory.
    function automatic void model(input bit st, input bit [2:0] f3, input bit [31:0] a,
                                  input bit [31:0] wd, output bit [31:0] rd, output bit [1:0] er);
        longint unsigned sz, la;
        bit [31:0] val;
        sz = longint'(sz_of(f3));
        la = longint'(a);
        if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (st && f3 >= 3'd4)) er = 2'd3;
        else if (la % sz != 0) er = 2'd1;
        else if (la + sz > 64'd4096) er = 2'd2;
        else er = 2'd0;
        rd = 32'd0;
        if (er == 2'd0 && !st) begin
            val = 32'd0;
            for (int i = 0; i < int'(sz); i++) val = val | (32'(ref_b[int'(la) + i]) << (8 * i));
            if (f3 == 3'd0 && val[7])  val = val | 32'hFFFF_FF00;
            if (f3 == 3'd1 && val[15]) val = val | 32'hFFFF_0000;
            rd = val;
        end
        if (er == 2'd0 && st) begin
            for (int i = 0; i < int'(sz); i++) ref_b[int'(la) + i] = byte'(wd >> (8 * i));
        end
    endfunction

    // One request with resp_ready high; called and returns one tick after a rising edge, unit idle.
    task automatic run_one(input string nm, input bit st, input bit [2:0] f3, input bit [31:0] a,
                           input bit [31:0] wd, input bit [31:0] exp_rd, input bit [1:0] exp_er);
        int lat, r0, w0, sz;
        r0 = n_read;
        w0 = n_write;
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        check({nm, "_rdata"}, resp_rdata, exp_rd);
        check({nm, "_err"}, 32'(resp_err), 32'(exp_er));
        check({nm, "_latency"}, lat, (exp_er == 2'd0) ? 2 : 1);
        @(posedge clk); #1;
        check({nm, "_req_ready"}, 32'(req_ready), 32'd1);
        check({nm, "_reads"}, n_read - r0, (exp_er == 2'd0 && !st) ? 1 : 0);
        check({nm, "_writes"}, n_write - w0, (exp_er == 2'd0 && st) ? 1 : 0);
        if (exp_er == 2'd0 && st) begin
            sz = sz_of(f3);
            check({nm, "_bus_addr"}, cap_addr, a & 32'hFFFF_FFFC);
            check({nm, "_bus_mask"}, 32'(cap_mask), ((32'd1 << sz) - 32'd1) << a[1:0]);
            check({nm, "_bus_wdata"}, cap_wdata, wd);
        end
    endtask

    typedef struct {
        bit        st;
        bit [2:0]  f3;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [31:0] exp_rd;
        bit [1:0]  exp_er;
    } vec_t;

    vec_t vecs[19];

    initial begin
        bit [31:0] rd, ref_word;
        bit [1:0]  er;
        bit        st;
        bit [2:0]  f3;
        bit [31:0] a, wd;
        int        r0, w0, bad;

        for (int i = 0; i < 1024; i++) mem_w[i] = 32'd0;
        for (int i = 0; i < 4096; i++) ref_b[i] = 8'd0;
        mem_w[32'h100 >> 2] = 32'h8899_AABB;
        ref_b[32'h100] = 8'hBB; ref_b[32'h101] = 8'hAA;
        ref_b[32'h102] = 8'h99; ref_b[32'h103] = 8'h88;

        vecs[0]  = '{1'b1, 3'd0, 32'h0000_0106, 32'h1234_5678, 32'h0000_0000, 2'd0};
        vecs[1]  = '{1'b0, 3'd0, 32'h0000_0103, 32'h0,         32'hFFFF_FF88, 2'd0};
        vecs[2]  = '{1'b0, 3'd4, 32'h0000_0103, 32'h0,         32'h0000_0088, 2'd0};
        vecs[3]  = '{1'b0, 3'd1, 32'h0000_0102, 32'h0,         32'hFFFF_8899, 2'd0};
        vecs[4]  = '{1'b0, 3'd5, 32'h0000_0100, 32'h0,         32'h0000_AABB, 2'd0};
        vecs[5]  = '{1'b0, 3'd2, 32'h0000_0100, 32'h0,         32'h8899_AABB, 2'd0};
        vecs[6]  = '{1'b0, 3'd2, 32'h0000_0102, 32'h0,         32'h0,         2'd1};
        vecs[7]  = '{1'b1, 3'd1, 32'h0000_0101, 32'hAAAA_5555, 32'h0,         2'd1};
        vecs[8]  = '{1'b0, 3'd3, 32'h0000_0100, 32'h0,         32'h0,         2'd3};
        vecs[9]  = '{1'b1, 3'd4, 32'h0000_0100, 32'h0000_00FF, 32'h0,         2'd3};
        vecs[10] = '{1'b0, 3'd2, 32'h0000_0FFC, 32'h0,         32'h0,         2'd0};
        vecs[11] = '{1'b0, 3'd2, 32'h0000_1000, 32'h0,         32'h0,         2'd2};
        vecs[12] = '{1'b1, 3'd1, 32'h0000_1FFE, 32'h0000_1234, 32'h0,         2'd2};
        vecs[13] = '{1'b0, 3'd0, 32'hFFFF_FFFF, 32'h0,         32'h0,         2'd2};
        vecs[14] = '{1'b0, 3'd4, 32'h0000_0106, 32'h0,         32'h0000_0078, 2'd0};
        vecs[15] = '{1'b0, 3'd7, 32'h0000_1001, 32'h0,         32'h0,         2'd3};
        vecs[16] = '{1'b0, 3'd2, 32'h0000_1002, 32'h0,         32'h0,         2'd1};
        vecs[17] = '{1'b1, 3'd1, 32'h0000_0FFE, 32'h0000_C3A5, 32'h0,         2'd0};
        vecs[18] = '{1'b0, 3'd1, 32'h0000_0FFE, 32'h0,         32'hFFFF_C3A5, 2'd0};

        rst_n = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b1;
        #2 rst_n = 1'b0;
        @(posedge clk); #1;
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_resp_valid", 32'(resp_valid), 32'd0);
        check("reset_rdata", resp_rdata, 32'd0);
        check("reset_err", 32'(resp_err), 32'd0);
        check("reset_cmd", 32'(|membuscmd), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 19; i++) begin
            model(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er);
            run_one($sformatf("vec%0d", i), vecs[i].st, vecs[i].f3, vecs[i].addr,
                    vecs[i].wdata, vecs[i].exp_rd, vecs[i].exp_er);
        end

        // Back-pressure: response held, tempting store request ignored, no bus traffic.
        model(1'b0, 3'd2, 32'h100, 32'd0, rd, er);
        resp_ready = 1'b0;
        req_valid = 1'b1; req_store = 1'b0; req_funct3 = 3'd2; req_addr = 32'h100;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int k = 0; k < 4 && !resp_valid; k++) begin
            @(posedge clk); #1;
        end
        r0 = n_read; w0 = n_write;
        for (int k = 0; k < 5; k++) begin
            req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd2; req_wdata = 32'd0;
            @(posedge clk); #1;
            check($sformatf("bp%0d_resp_valid", k), 32'(resp_valid), 32'd1);
            check($sformatf("bp%0d_rdata", k), resp_rdata, rd);
            check($sformatf("bp%0d_err", k), 32'(resp_err), 32'd0);
            check($sformatf("bp%0d_req_ready", k), 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        check("bp_no_bus", (n_read - r0) + (n_write - w0), 0);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_req_ready", 32'(req_ready), 32'd1);
        check("bp_release_resp_valid", 32'(resp_valid), 32'd0);

        // Reset asserted mid-ACCESS of a word store: write must never land.
        ref_word = {ref_b[32'h203], ref_b[32'h202], ref_b[32'h201], ref_b[32'h200]};
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'd2;
        req_addr = 32'h200; req_wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rst_access_write", 32'(membuscmd.mem_write), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mem_write", 32'(membuscmd.mem_write), 32'd0);
        check("rst_cmd_zero", 32'(|membuscmd), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        @(posedge clk); #1;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_mem_unchanged", mem_w[32'h200 >> 2], ref_word);
        check("rst_resp_rdata", resp_rdata, 32'd0);

        for (int n = 0; n < 300; n++) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                8:       a = 32'd4088 + 32'($urandom_range(0, 15));
                9:       a = $urandom;
                default: a = 32'($urandom_range(0, 4095));
            endcase
            wd = $urandom;
            model(st, f3, a, wd, rd, er);
            run_one($sformatf("rnd%0d", n), st, f3, a, wd, rd, er);
        end

        bad = 0;
        for (int w = 0; w < 1024; w++) begin
            if (mem_w[w] != {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]}) bad++;
        end
        check("mem_consistency", bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute stage and the data memory.
- Takes one load/store request per handshake and checks alignment, range and opcode.
- Issues exactly one MemoryBus::Cmd transaction for each legal request.
- Returns sign/zero-extended load data or a store completion, with an error code, through a valid/ready response.

Parameters:
DMEM_BASE, 32'h0000_0000, lowest legal byte address.
DMEM_SIZE, 4096, data memory size in bytes; must be a power of two and a multiple of 4.

Ports:
clk  in  1  clock.
rst_n  in  1  reset; asynchronous, active-low. One clock domain.
req_valid  in  1  request present.
req_ready  out  1  unit can accept a request.
req_store  in  1  1 = store, 0 = load.
req_funct3  in  3  RISC-V funct3: 0 B, 1 H, 2 W, 4 BU, 5 HU.
req_addr  in  32  byte address.
req_wdata  in  32  store data, low-justified.
resp_valid  out  1  response present.
resp_ready  in  1  consumer accepts the response.
resp_rdata  out  32  extended load data; 0 for stores and errors.
resp_err  out  2  0 OK, 1 misaligned, 2 access fault, 3 illegal op.
membuscmd  out  MemoryBus::Cmd  address, write_data, mem_read, mem_write, mask_byte.
membusres  in  MemoryBus::Result  read_data; combinational, valid in the same cycle as mem_read.

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- Reset (async, rst_n=0):
  - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - membuscmd all fields 0.
  - Reset during ACCESS aborts the transaction; the write must not occur (mem_write is forced low combinationally).
- IDLE:
  - req_ready=1.
  - On req_valid, latch store, funct3, addr and wdata, and compute err.
  - err!=0 -> RESP with no bus activity; err==0 -> ACCESS.
- Error priority: illegal (funct3 in {3,6,7}, or store with funct3 in {4,5}) > misaligned > access fault.
  - Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0.
  - Access fault: addr < DMEM_BASE, or addr+size-1 >= DMEM_BASE+DMEM_SIZE. Compute this in 33 bits so there is no wrap-around.
- ACCESS (exactly one cycle):
  - membuscmd.address = {addr[31:2],2'b00}.
  - Loads: mem_read=1; the lane-extracted read_data is registered into resp_rdata at the clock edge.
  - Stores: mem_write=1; write_data = wdata, low-justified (the memory places the low bytes into the masked lanes).
  - mask_byte: B = 1<<addr[1:0]; H = 3<<addr[1:0] (values 3 or 12); W = 15. Loads drive mask 0.
  - Next state: RESP.
- Outside ACCESS all membuscmd fields are 0.
- Load extraction:
  - B/BU: byte read_data[8*addr[1:0]+:8].
  - H/HU: halfword read_data[16*addr[1]+:16].
  - B and H sign-extend; BU and HU zero-extend; W passes through.
- RESP:
  - resp_valid=1; req_ready=0.
  - resp_rdata and resp_err are held stable until resp_ready=1, then IDLE.
  - A new request is not accepted in the same cycle (no bypass).
- Throughput and latency:
  - Legal request: accepted at edge N, response visible after edge N+2. One request per 3 cycles minimum.
  - Error request: response visible after edge N+1.
- Back-pressure: resp_ready held low keeps the unit in RESP indefinitely, with no further bus commands.

Decomposition:
- Package Lsu (new), holding:
  - funct3 enum: LS_B, LS_H, LS_W, LS_BU, LS_HU.
  - LsuErr enum: ERR_NONE, ERR_MISALIGNED, ERR_ACCESS_FAULT, ERR_ILLEGAL.
  - State enum.
  - Byte-size function.
- uint32 comes from Common; Cmd and Result come from MemoryBus, both unchanged.
- One combinational sub-module, lsu_lane_align, holding the pure data path:
  - Inputs: funct3, addr[1:0], read_data.
  - Outputs: mask_byte and extended load data.
- The FSM, range check and registers stay in load_store_unit.

Test Plan:
- SB addr 0x0000_0106, wdata 0x1234_5678 -> one ACCESS cycle with address 0x104, mask 4, write_data 0x1234_5678, mem_write=1. Response: err 0, rdata 0.
- Memory word 0x100 = 0x8899_AABB. LB 0x103 -> 0xFFFF_FF88; LBU 0x103 -> 0x0000_0088; LH 0x102 -> 0xFFFF_8899; LHU 0x100 -> 0x0000_AABB; LW 0x100 -> 0x8899_AABB. Each response appears 2 cycles after acceptance.
- LW 0x102 -> err 1; SH 0x101 -> err 1; funct3 3 -> err 3; SB funct3 4 -> err 3. For all of these, mem_read and mem_write stay 0 throughout and the response appears 1 cycle after acceptance.
- DMEM_SIZE 4096: LW 0xFFC -> err 0; LW 0x1000 -> err 2; SH 0x1FFE -> err 2; LB 0xFFFF_FFFF -> err 2.
- Hold resp_ready=0 for 5 cycles: resp_valid, rdata and err are stable, req_ready=0, and no bus activity. Then raise resp_ready -> IDLE next cycle and req_ready=1.
- Assert rst_n=0 mid-cycle during a SW ACCESS -> mem_write drops immediately, the memory word is unchanged, and all outputs take their reset values asynchronously.
